cordic_rotate: RTL

Rotation-mode CORDIC: converts a polar pair (magnitude, angle) to Cartesian (x, y). It is the inverse of the vectoring-mode angle estimator and uses the same angle format and the same `cordic_rom` arctangent table, so angles round-trip between the two blocks without rescaling. It is iterative, with one micro-rotation per clock, and is used in the baseband path to synthesize I/Q from phase/amplitude words.

---
 rtl/cordic_rotate_if.sv | 26 ++
 rtl/cordic_rotate.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/cordic_rotate_if.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | cordic_rotate_if : request/result bundle for the rotation CORDIC   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface cordic_rotate_if;
  logic               start;
  logic signed [15:0] angle_in;
  logic        [7:0]  mag;
  logic signed [8:0]  x_out;
  logic signed [8:0]  y_out;
  logic               done;
  logic               ready;

  modport master (
    output start, angle_in, mag,
    input  x_out, y_out, done, ready
  );

  modport slave (
    input  start, angle_in, mag,
    output x_out, y_out, done, ready
  );
endinterface
`default_nettype wire

// File: rtl/cordic_rotate.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | cordic_rotate : iterative rotation-mode CORDIC, (mag, angle)->(x,y)|
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module cordic_rotate #(
  parameter int STAGES = 10,
  parameter int IW     = 12
) (
  input  logic            clk,
  input  logic            resetn,
  cordic_rotate_if.slave  bus
);

  localparam logic signed [15:0]   ANG_MAX  = 16'sd23040;
  localparam logic signed [15:0]   ANG_MIN  = -16'sd23040;
  localparam logic signed [15:0]   ANG_HALF = 16'sd11520;
  localparam logic signed [15:0]   ANG_NHLF = -16'sd11520;
  localparam logic signed [IW-1:0] SAT_HI   = IW'(255);
  localparam logic signed [IW-1:0] SAT_LO   = IW'(-255);
  localparam logic [3:0]           LAST_STG = 4'(STAGES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ROTATE = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  // atan(2^-i) in degrees x128, shared with the vectoring estimator
  function automatic logic [12:0] cordic_rom(input logic [3:0] idx);
    case (idx)
      4'd0:    cordic_rom = 13'd5760;
      4'd1:    cordic_rom = 13'd3400;
      4'd2:    cordic_rom = 13'd1797;
      4'd3:    cordic_rom = 13'd912;
      4'd4:    cordic_rom = 13'd458;
      4'd5:    cordic_rom = 13'd229;
      4'd6:    cordic_rom = 13'd115;
      4'd7:    cordic_rom = 13'd57;
      4'd8:    cordic_rom = 13'd29;
      4'd9:    cordic_rom = 13'd14;
      default: cordic_rom = 13'd0;
    endcase
  endfunction

  state_t                state_q, state_d;
  logic signed [IW-1:0]  x_q, x_d, y_q, y_d;
  logic signed [15:0]    z_q, z_d;
  logic        [3:0]     stage_q, stage_d;
  logic                  flip_q, flip_d;
  logic signed [8:0]     x_out_q, x_out_d, y_out_q, y_out_d;
  logic                  done_q, done_d, ready_q, ready_d;

  logic signed [15:0]    a_clamp;
  logic        [9:0]     m;
  logic        [10:0]    pre;
  logic signed [IW-1:0]  shx, shy, xf, yf, xs, ys;
  logic        [15:0]    atan;

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    stage_d = stage_q;
    flip_d  = flip_q;
    x_out_d = x_out_q;
    y_out_d = y_out_q;
    done_d  = done_q;
    ready_d = ready_q;

    a_clamp = bus.angle_in;
    if (bus.angle_in > ANG_MAX)      a_clamp = ANG_MAX;
    else if (bus.angle_in < ANG_MIN) a_clamp = ANG_MIN;

    // 1/K gain compensation: 1/2 + 1/8 - 1/64 - 1/512
    m   = {bus.mag, 2'b00};
    pre = {1'b0, m >> 1} + {1'b0, m >> 3} - {1'b0, m >> 6} - {1'b0, m >> 9};

    shx  = x_q >>> stage_q;
    shy  = y_q >>> stage_q;
    atan = {3'b000, cordic_rom(stage_q)};

    xf = flip_q ? -x_q : x_q;
    yf = flip_q ? -y_q : y_q;
    xs = xf >>> 2;
    ys = yf >>> 2;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (a_clamp > ANG_HALF) begin
            z_d    = a_clamp - ANG_MAX;
            flip_d = 1'b1;
          end else if (a_clamp < ANG_NHLF) begin
            z_d    = a_clamp + ANG_MAX;
            flip_d = 1'b1;
          end else begin
            z_d    = a_clamp;
            flip_d = 1'b0;
          end
          x_d     = IW'($signed({1'b0, pre}));
          y_d     = '0;
          stage_d = 4'd0;
          ready_d = 1'b0;
          done_d  = 1'b0;
          state_d = S_ROTATE;
        end
      end
      S_ROTATE: begin
        if (!z_q[15]) begin
          x_d = x_q - shy;
          y_d = y_q + shx;
          z_d = z_q - $signed(atan);
        end else begin
          x_d = x_q + shy;
          y_d = y_q - shx;
          z_d = z_q + $signed(atan);
        end
        if (stage_q == LAST_STG) state_d = S_FINISH;
        else                     stage_d = stage_q + 4'd1;
      end
      S_FINISH: begin
        if (xs > SAT_HI)      x_out_d = 9'sd255;
        else if (xs < SAT_LO) x_out_d = -9'sd255;
        else                  x_out_d = xs[8:0];
        if (ys > SAT_HI)      y_out_d = 9'sd255;
        else if (ys < SAT_LO) y_out_d = -9'sd255;
        else                  y_out_d = ys[8:0];
        done_d  = 1'b1;
        ready_d = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      stage_q <= '0;
      flip_q  <= 1'b0;
      x_out_q <= '0;
      y_out_q <= '0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      stage_q <= stage_d;
      flip_q  <= flip_d;
      x_out_q <= x_out_d;
      y_out_q <= y_out_d;
      done_q  <= done_d;
      ready_q <= ready_d;
    end
  end

  assign bus.x_out = x_out_q;
  assign bus.y_out = y_out_q;
  assign bus.done  = done_q;
  assign bus.ready = ready_q;

endmodule
`default_nettype wire
